// File: rtl/metronome_click_gen.sv
// Beat-trigger consumer: converts each beat pulse into a fixed-length tone burst,
// with an accent pitch on the first beat of each bar, and exports beat position/status.
module metronome_click_gen #(
    parameter int CLICK_LEN   = 2_500_000,
    parameter int HALF_NORMAL = 25_000,
    parameter int HALF_ACCENT = 12_500
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_trigger,
    input  logic [3:0] i_beats_per_bar,
    input  logic       i_mute,
    output logic       o_beep,
    output logic [3:0] o_beat_index,
    output logic       o_accent,
    output logic       o_busy,
    output logic       o_beat_strobe
);

    localparam int HALF_MAX = (HALF_NORMAL > HALF_ACCENT) ? HALF_NORMAL : HALF_ACCENT;
    localparam int LEN_W    = (CLICK_LEN > 1) ? $clog2(CLICK_LEN) : 1;
    localparam int PH_W     = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    localparam logic [LEN_W-1:0] LEN_LAST  = LEN_W'(CLICK_LEN - 1);
    localparam logic [PH_W-1:0]  PH_LAST_N = PH_W'(HALF_NORMAL - 1);
    localparam logic [PH_W-1:0]  PH_LAST_A = PH_W'(HALF_ACCENT - 1);

    typedef enum logic {
        IDLE,
        TONE
    } state_t;

    state_t           state;
    logic [3:0]       next_idx;
    logic [LEN_W-1:0] len_cnt;
    logic [PH_W-1:0]  phase;
    logic             tone;

    logic [3:0]       eff_idx;
    logic [4:0]       eff_inc;
    logic [3:0]       idx_after;
    logic [PH_W-1:0]  ph_last;

    // A stale next_idx beyond the current bar length folds back to the downbeat.
    always_comb begin
        eff_idx   = (next_idx >= i_beats_per_bar) ? 4'd0 : next_idx;
        eff_inc   = {1'b0, eff_idx} + 5'd1;
        idx_after = '0;
        if (i_beats_per_bar != 4'd0 && eff_inc < {1'b0, i_beats_per_bar})
            idx_after = eff_inc[3:0];
        ph_last = o_accent ? PH_LAST_A : PH_LAST_N;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            next_idx      <= '0;
            len_cnt       <= '0;
            phase         <= '0;
            tone          <= 1'b0;
            o_beat_index  <= '0;
            o_accent      <= 1'b0;
            o_beat_strobe <= 1'b0;
        end else begin
            o_beat_strobe <= i_trigger;
            if (i_trigger) begin
                o_beat_index <= eff_idx;
                o_accent     <= (i_beats_per_bar != 4'd0) && (eff_idx == 4'd0);
                next_idx     <= idx_after;
                len_cnt      <= '0;
                phase        <= '0;
                tone         <= 1'b1;
                state        <= TONE;
            end else if (state == TONE) begin
                if (phase == ph_last) begin
                    phase <= '0;
                    tone  <= ~tone;
                end else begin
                    phase <= phase + PH_W'(1);
                end
                if (len_cnt == LEN_LAST) begin
                    state <= IDLE;
                    tone  <= 1'b0;
                end else begin
                    len_cnt <= len_cnt + LEN_W'(1);
                end
            end
        end
    end

    assign o_beep = tone & ~i_mute;
    assign o_busy = (state == TONE);

endmodule

// File: tb/tb_metronome_click_gen.sv
// Self-checking bench for metronome_click_gen: beat index/accent scoreboard plus
// per-cycle waveform checks of beep, busy and strobe against the intended click shape.
module tb_metronome_click_gen;

    localparam int CLICK_LEN   = 20;
    localparam int HALF_NORMAL = 4;
    localparam int HALF_ACCENT = 2;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_trigger;
    logic [3:0] i_beats_per_bar;
    logic       i_mute;
    logic       o_beep;
    logic [3:0] o_beat_index;
    logic       o_accent;
    logic       o_busy;
    logic       o_beat_strobe;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [4:0] exp_q[$];

    metronome_click_gen #(
        .CLICK_LEN  (CLICK_LEN),
        .HALF_NORMAL(HALF_NORMAL),
        .HALF_ACCENT(HALF_ACCENT)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_trigger      (i_trigger),
        .i_beats_per_bar(i_beats_per_bar),
        .i_mute         (i_mute),
        .o_beep         (o_beep),
        .o_beat_index   (o_beat_index),
        .o_accent       (o_accent),
        .o_busy         (o_busy),
        .o_beat_strobe  (o_beat_strobe)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each strobe retires the oldest expected {index, accent} pair.
    always @(negedge i_clk) begin
        if (!i_reset && o_beat_strobe) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                chk("beat_index", 32'(o_beat_index), 32'(e[4:1]));
                chk("accent", 32'(o_accent), 32'(e[0]));
            end
        end
    end

    // Called #1 after a clock edge; drives a trigger sampled at the next edge.
    task automatic fire(input logic [3:0] idx, input logic acc, input logic busy_now);
        exp_q.push_back({idx, acc});
        i_trigger = 1'b1;
        @(negedge i_clk);
        chk("busy_at_trigger", 32'(o_busy), 32'(busy_now));
        @(posedge i_clk);
        #1;
        i_trigger = 1'b0;
    endtask

    // Cycle k=0 is the first cycle after the trigger edge.
    task automatic watch(input int half, input int ncyc, input int mute_from, input int mute_to);
        for (int k = 0; k < ncyc; k++) begin
            logic in_click, exp_beep;
            i_mute   = (k >= mute_from) && (k < mute_to);
            in_click = (k < CLICK_LEN);
            exp_beep = in_click && (((k / half) % 2) == 0) && !i_mute;
            @(negedge i_clk);
            chk("beep", 32'(o_beep), 32'(exp_beep));
            chk("busy", 32'(o_busy), 32'(in_click));
            chk("strobe", 32'(o_beat_strobe), 32'(k == 0));
            @(posedge i_clk);
            #1;
        end
        i_mute = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        @(negedge i_clk);
        chk({tag, "_beep"}, 32'(o_beep), 32'd0);
        chk({tag, "_idx"}, 32'(o_beat_index), 32'd0);
        chk({tag, "_accent"}, 32'(o_accent), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_strobe"}, 32'(o_beat_strobe), 32'd0);
    endtask

    initial begin
        i_reset         = 1'b1;
        i_trigger       = 1'b0;
        i_mute          = 1'b0;
        i_beats_per_bar = 4'd4;
        repeat (3) @(posedge i_clk);
        #1;
        chk_all_zero("reset");
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Full bar of four beats: accent, three normal, accent again.
        fire(4'd0, 1'b1, 1'b0); watch(HALF_ACCENT, 30, -1, -1);
        fire(4'd1, 1'b0, 1'b0); watch(HALF_NORMAL, 30, -1, -1);
        fire(4'd2, 1'b0, 1'b0); watch(HALF_NORMAL, 30, -1, -1);
        fire(4'd3, 1'b0, 1'b0); watch(HALF_NORMAL, 30, -1, -1);
        fire(4'd0, 1'b1, 1'b0); watch(HALF_ACCENT, 30, -1, -1);

        // Retrigger seven cycles in: busy stays up, new window and phase restart.
        fire(4'd1, 1'b0, 1'b0); watch(HALF_NORMAL, 7, -1, -1);
        fire(4'd2, 1'b0, 1'b1); watch(HALF_NORMAL, 30, -1, -1);

        // next_idx is 3; shrinking the bar to 2 folds it back to the downbeat.
        i_beats_per_bar = 4'd2;
        fire(4'd0, 1'b1, 1'b0); watch(HALF_ACCENT, 30, -1, -1);
        fire(4'd1, 1'b0, 1'b0); watch(HALF_NORMAL, 30, -1, -1);

        // Counting disabled: always index 0, never accented.
        i_beats_per_bar = 4'd0;
        fire(4'd0, 1'b0, 1'b0); watch(HALF_NORMAL, 30, -1, -1);
        fire(4'd0, 1'b0, 1'b0); watch(HALF_NORMAL, 30, -1, -1);

        // Muted first half of a click, then unmuted mid-click.
        fire(4'd0, 1'b0, 1'b0); watch(HALF_NORMAL, 30, 0, 10);

        // Trigger coincident with the click-end edge.
        fire(4'd0, 1'b0, 1'b0); watch(HALF_NORMAL, CLICK_LEN - 1, -1, -1);
        fire(4'd0, 1'b0, 1'b1); watch(HALF_NORMAL, 30, -1, -1);

        // Reset with simultaneous trigger mid-click; next_idx must return to 0.
        i_beats_per_bar = 4'd4;
        fire(4'd0, 1'b1, 1'b0); watch(HALF_ACCENT, 5, -1, -1);
        i_reset   = 1'b1;
        i_trigger = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset   = 1'b0;
        i_trigger = 1'b0;
        chk_all_zero("reset_trig");
        @(posedge i_clk);
        #1;
        fire(4'd0, 1'b1, 1'b0); watch(HALF_ACCENT, 30, -1, -1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/metronome_click_gen.md
# metronome_click_gen

Consumer end of the metronome beat interface: accepts the one-cycle beat trigger pulse produced by the tempo generator and turns each pulse into an audible click on a piezo/speaker pin. Tracks the beat position within a bar and sounds the first beat of every bar at a higher (accent) pitch. Sits between the tempo generator and the board buzzer pin. Also exports beat position and status for the display logic.

## Interface
Parameters:
- CLICK_LEN, 2_500_000, click duration in clock cycles (50 ms at 50 MHz)
- HALF_NORMAL, 25_000, half-period in cycles of the normal tone (1 kHz at 50 MHz)
- HALF_ACCENT, 12_500, half-period in cycles of the accent tone (2 kHz at 50 MHz)

Ports:
- i_clk  input  1  system clock; single clock domain
- i_reset  input  1  synchronous, active-high reset
- i_trigger  input  1  one-cycle beat pulse from the tempo generator
- i_beats_per_bar  input  4  beats per bar; 0 disables accent and beat counting
- i_mute  input  1  forces o_beep low; all timing continues
- o_beep  output  1  square-wave drive to the buzzer
- o_beat_index  output  4  index of the last started beat, 0-based
- o_accent  output  1  current or last click is an accent click
- o_busy  output  1  click in progress
- o_beat_strobe  output  1  one-cycle pulse when a click starts

## Operation
- Two states: IDLE, TONE. Reset -> IDLE.
- Internal next_idx (4 bit): index the next beat will take. Reset 0.
- Trigger accepted in either state (checked every cycle i_trigger=1):
  - effective index e = (next_idx >= i_beats_per_bar) ? 0 : next_idx; with i_beats_per_bar=0, e = 0.
  - o_beat_index <= e; o_accent <= (i_beats_per_bar != 0) && (e == 0).
  - next_idx <= (i_beats_per_bar == 0 || e+1 >= i_beats_per_bar) ? 0 : e+1.
  - len_cnt <= 0, tone phase counter <= 0, tone level <= 1, state <= TONE, o_beat_strobe <= 1.
- Trigger in TONE aborts the current click and restarts (retrigger); no queuing.
- TONE: len_cnt increments each cycle; phase counter increments and on reaching half-1 (HALF_ACCENT if o_accent else HALF_NORMAL) wraps to 0 and tone level toggles. When len_cnt = CLICK_LEN-1 and no trigger: state <= IDLE, tone level <= 0.
- o_beep = tone level & ~i_mute (combinational mask; registered level).
- o_busy = (state == TONE).
- i_beats_per_bar change mid-bar takes effect at the next trigger via the clamp rule above; no effect on a click in progress.
- Counter widths: len_cnt and phase counter sized by $clog2 of their parameter; no wrap beyond terminal value.

## Timing
- Reset values: o_beep 0, o_beat_index 0, o_accent 0, o_busy 0, o_beat_strobe 0, next_idx 0, state IDLE.
- Reset has priority over a simultaneous trigger.
- Trigger sampled at edge N -> o_beat_strobe, o_busy, o_beep (unmuted) high from cycle N+1. Strobe lasts exactly 1 cycle.
- o_busy high for exactly CLICK_LEN cycles (N+1 .. N+CLICK_LEN) absent retrigger.
- o_beep high for first HALF cycles, low for next HALF, repeating; forced 0 after click end even mid-half-period.
- Retrigger at edge M during TONE: new click counted from M+1, o_busy never deasserts.
- Trigger on the same edge as click end: retrigger wins, o_busy stays high.

## Test plan
Bench params CLICK_LEN=20, HALF_NORMAL=4, HALF_ACCENT=2.
- Reset, then single trigger with i_beats_per_bar=4 -> strobe one cycle; o_accent=1, o_beat_index=0; o_beep pattern 1,1,0,0 repeating for 20 cycles; o_busy high exactly 20 cycles then all low.
- Four further triggers 30 cycles apart, bpb=4 -> o_beat_index 1,2,3,0; o_accent 0,0,0,1; normal clicks use 4-cycle halves.
- Retrigger 7 cycles into a click -> o_busy continuous, new 20-cycle window from retrigger+1, beat index advances, beep phase restarts high.
- bpb=4 at index 3 (next_idx 3), change bpb to 2, trigger -> o_beat_index=0, o_accent=1; next trigger -> index 1. bpb=0 -> every click index 0, o_accent=0.
- i_mute=1 during a click -> o_beep 0 throughout, o_busy and strobe unchanged; unmute mid-click -> o_beep resumes in correct phase.
- Assert i_reset mid-click together with i_trigger -> next cycle all outputs 0; following trigger yields index 0 with accent.
